// File: rtl/seq_divider_unit.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One quotient bit per clock; divide by zero reports all-ones quotient and passes the dividend through.
module seq_divider_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH:0]   rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] diff;
  logic                  no_borrow;
  logic [DATA_WIDTH:0]   rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic                  divisor_zero;
  logic                  accept;
  logic                  finish;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A zero divisor still spends one non-busy cycle in CALC so its result lands one edge after acceptance.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          accept     = 1'b1;
          next_state = CALC;
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        busy = !divisor_zero;
        if (divisor_zero || cnt_q == LAST_ITER) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    divisor_zero = (dvs_q == '0);
    shifted      = {rem_q, dvd_q[DATA_WIDTH-1]};
    diff         = shifted - {2'b00, dvs_q};
    no_borrow    = !diff[DATA_WIDTH+1];
    rem_next     = no_borrow ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
    quo_next     = {quo_q[DATA_WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        rem_q <= '0;
        quo_q <= '0;
        cnt_q <= '0;
      end else if (state == CALC) begin
        dvd_q <= {dvd_q[DATA_WIDTH-2:0], 1'b0};
        rem_q <= rem_next;
        quo_q <= quo_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Results only move on the edge that enters DONE and hold otherwise.
      if (finish) begin
        if (divisor_zero) begin
          quotient    <= '1;
          remainder   <= dvd_q;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= quo_next;
          remainder   <= rem_next[DATA_WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule
